// File: rtl/ssds_display_sequencer.sv
// ssds_display_sequencer: bus master turning value/valid requests into CTRL, DIGITS, DOTS writes to the SSD peripheral.
//
// Ports:
//   clk, rst (async, active-high)
//   req_valid/req_ready/req_value[15:0]/req_dots[3:0]/req_en : client request handshake and payload
//   busy, err (sticky timeout, cleared on next accept)
//   bus_req/bus_grant : arbiter handshake
//   addr_bus[31:0], data_bus[31:0] (inout), rd_bus, wr_bus, data_mask_bus[3:0] : tri-stated bus, driven only while granted and active
//   fc_bus : function complete from slave
//
// Build option: define SSDS_SEQ_BLANK_LEADING_ZEROS_EN to blank leading zero digits (digit 0 never blanked).
module ssds_display_sequencer #(
  parameter logic [31:0] SSDS_BASE_ADDR = 32'h0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_value,
  input  logic [3:0]  req_dots,
  input  logic        req_en,
  output logic        busy,
  output logic        err,
  output logic        bus_req,
  input  logic        bus_grant,
  output logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  output logic        rd_bus,
  output logic        wr_bus,
  output logic [3:0]  data_mask_bus,
  input  logic        fc_bus
);
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  typedef enum logic [1:0] {IDLE, ARB, WRITE, RELEASE} state_t;
  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [15:0] val_q, val_d;
  logic [3:0] dots_q, dots_d;
  logic en_q, en_d, err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic tmo_hit, drive;
  logic [31:0] digits, wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      val_q <= '0;
      dots_q <= '0;
      en_q <= 1'b0;
      err_q <= 1'b0;
      tmo_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      val_q <= val_d;
      dots_q <= dots_d;
      en_q <= en_d;
      err_q <= err_d;
      tmo_q <= tmo_d;
    end
  // Timeout fires on the cycle the counter has spent TIMEOUT_CYCLES cycles in the current phase.
  assign tmo_hit = tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    val_d = val_q;
    dots_d = dots_q;
    en_d = en_q;
    err_d = err_q;
    tmo_d = tmo_q + 1'b1;
    case (state_q)
      IDLE: if (req_valid) begin
        val_d = req_value;
        dots_d = req_dots;
        en_d = req_en;
        err_d = 1'b0;
        idx_d = '0;
        state_d = ARB;
      end
      ARB: if (bus_grant) begin
        state_d = WRITE;
        tmo_d = '0;
      end
      WRITE: if (fc_bus) begin
        state_d = RELEASE;
        tmo_d = '0;
      end else if (tmo_hit) begin
        state_d = IDLE;
        err_d = 1'b1;
      end
      RELEASE: if (!fc_bus) begin
        state_d = (idx_q == 2'd2) ? IDLE : WRITE;
        idx_d = (idx_q == 2'd2) ? idx_q : idx_q + 2'd1;
        tmo_d = '0;
      end else if (tmo_hit) begin
        state_d = IDLE;
        err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    req_ready = state_q == IDLE;
    busy = state_q != IDLE;
    bus_req = state_q != IDLE;
    err = err_q;
  end
  for (genvar g = 0; g < 4; g++) begin : g_dig
`ifdef SSDS_SEQ_BLANK_LEADING_ZEROS_EN
    assign digits[8*g+:8] = (g > 0 && val_q[15:4*g] == '0) ? 8'h00 : {4'h8, val_q[4*g+:4]};
`else
    assign digits[8*g+:8] = {4'h8, val_q[4*g+:4]};
`endif
  end
  assign wdata = (idx_q == 2'd0) ? {31'b0, en_q} : (idx_q == 2'd1) ? digits : {28'b0, dots_q};
  assign drive = (state_q == WRITE || state_q == RELEASE) && bus_grant;
  assign addr_bus = drive ? SSDS_BASE_ADDR + {28'b0, idx_q, 2'b00} : 'z;
  assign wr_bus = drive ? state_q == WRITE : 1'bz;
  assign rd_bus = drive ? 1'b0 : 1'bz;
  assign data_mask_bus = drive ? 4'hF : 4'hz;
  assign data_bus = (drive && state_q == WRITE) ? wdata : 'z;
endmodule

// File: tb/tb_ssds_display_sequencer.sv
// tb_ssds_display_sequencer: self-checking bench for ssds_display_sequencer with a simple responding slave.
module tb_ssds_display_sequencer;
  localparam logic [31:0] BASE = 32'h4000_0100;
`ifdef SSDS_SEQ_BLANK_LEADING_ZEROS_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  logic clk = 0, rst = 1, req_valid = 0, req_en = 0, bus_grant = 1, fc_bus = 0;
  logic [15:0] req_value = '0;
  logic [3:0] req_dots = '0;
  logic req_ready, busy, err, bus_req;
  wire [31:0] addr_bus, data_bus;
  wire rd_bus, wr_bus;
  wire [3:0] data_mask_bus;
  int total = 0, passed = 0, wr_cyc = 0, hold_n = 0, hold_cnt = 0;
  bit stuck = 0, arb_bad = 0;
  logic [63:0] got[$];
  typedef struct {
    logic [15:0] v;
    logic [3:0] d;
    logic e;
    logic [31:0] dig_hex;
    logic [31:0] dig_blank;
  } vec_t;
  vec_t tbl[6];

  ssds_display_sequencer #(.SSDS_BASE_ADDR(BASE), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_value(req_value), .req_dots(req_dots), .req_en(req_en), .busy(busy), .err(err),
    .bus_req(bus_req), .bus_grant(bus_grant), .addr_bus(addr_bus), .data_bus(data_bus),
    .rd_bus(rd_bus), .wr_bus(wr_bus), .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
  );

  always #5 clk = ~clk;

  // Slave: one-cycle fc pulse per write, optionally held hold_n extra cycles, or never answering.
  always @(posedge clk or posedge rst)
    if (rst) begin
      fc_bus <= 1'b0;
      hold_cnt <= 0;
    end else if (stuck) fc_bus <= 1'b0;
    else if (wr_bus === 1'b1 && !fc_bus) begin
      fc_bus <= 1'b1;
      hold_cnt <= hold_n;
    end else if (fc_bus && hold_cnt > 0) hold_cnt <= hold_cnt - 1;
    else fc_bus <= 1'b0;

  always @(negedge clk) begin
    if (wr_bus === 1'b1) wr_cyc++;
    if (!rst && wr_bus === 1'b1 && fc_bus) got.push_back({addr_bus, data_bus});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] exp_data(input logic [15:0] v, input logic [3:0] d, input logic e, input int k);
    logic [31:0] dg = '0;
    if (k == 0) return {31'b0, e};
    if (k == 2) return {28'b0, d};
    for (int i = 0; i < 4; i++) begin
      int hi = int'(v) / (16 ** i);
      int b = (BLANK && i > 0 && hi == 0) ? 0 : 128 + hi % 16;
      dg = dg + 32'(b) * (32'h1 << (8 * i));
    end
    return dg;
  endfunction

  task automatic run_req(input logic [15:0] v, input logic [3:0] d, input logic e, input int gd, output int cyc);
    got.delete();
    wr_cyc = 0;
    arb_bad = 0;
    @(negedge clk);
    req_value = v;
    req_dots = d;
    req_en = e;
    req_valid = 1;
    bus_grant = (gd == 0);
    @(negedge clk);
    req_valid = 0;
    cyc = 0;
    while (busy && cyc < 300) begin
      if (!bus_grant && (bus_req !== 1'b1 || wr_bus === 1'b1 || data_mask_bus === 4'hF)) arb_bad = 1;
      if (cyc == gd) bus_grant = 1;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_writes(input string nm, input logic [15:0] v, input logic [3:0] d, input logic e);
    chk($sformatf("%s write count", nm), 64'(got.size()), 64'd3);
    for (int k = 0; k < 3 && k < got.size(); k++)
      chk($sformatf("%s write %0d", nm, k), got[k], {BASE + 32'(4 * k), exp_data(v, d, e, k)});
  endtask

  initial begin
    int cyc, n, gd;
    logic [15:0] rv;
    logic [3:0] rd;
    logic re;
    tbl[0] = '{16'h1A3F, 4'b0101, 1'b1, 32'h818A838F, 32'h818A838F};
    tbl[1] = '{16'h004F, 4'b0000, 1'b0, 32'h8080848F, 32'h0000848F};
    tbl[2] = '{16'h0000, 4'b1111, 1'b1, 32'h80808080, 32'h00000080};
    tbl[3] = '{16'hFFFF, 4'b1010, 1'b0, 32'h8F8F8F8F, 32'h8F8F8F8F};
    tbl[4] = '{16'h0100, 4'b0011, 1'b1, 32'h80818080, 32'h00818080};
    tbl[5] = '{16'h000A, 4'b1000, 1'b1, 32'h8080808A, 32'h0000008A};
    #12;
    chk("reset req_ready", 64'(req_ready), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset err", 64'(err), 64'd0);
    chk("reset bus_req", 64'(bus_req), 64'd0);
    chk("reset bus released", 64'(data_mask_bus === 4'hF || wr_bus === 1'b1), 64'd0);
    @(negedge clk);
    rst = 0;
    foreach (tbl[i]) begin
      run_req(tbl[i].v, tbl[i].d, tbl[i].e, 0, cyc);
      chk($sformatf("tbl%0d latency", i), 64'(cyc), 64'd10);
      chk($sformatf("tbl%0d count", i), 64'(got.size()), 64'd3);
      if (got.size() == 3) begin
        chk($sformatf("tbl%0d ctrl", i), got[0], {BASE, 31'b0, tbl[i].e});
        chk($sformatf("tbl%0d digits", i), got[1], {BASE + 32'd4, BLANK ? tbl[i].dig_blank : tbl[i].dig_hex});
        chk($sformatf("tbl%0d dots", i), got[2], {BASE + 32'd8, 28'b0, tbl[i].d});
      end
      chk($sformatf("tbl%0d err", i), 64'(err), 64'd0);
    end
    run_req(16'h1A3F, 4'b0101, 1'b1, 20, cyc);
    chk("grant wait bus quiet", 64'(arb_bad), 64'd0);
    chk("grant wait latency", 64'(cyc), 64'd30);
    check_writes("grant wait", 16'h1A3F, 4'b0101, 1'b1);
    hold_n = 3;
    run_req(16'hBEEF, 4'b1001, 1'b0, 0, cyc);
    hold_n = 0;
    chk("fc hold latency", 64'(cyc), 64'd19);
    check_writes("fc hold", 16'hBEEF, 4'b1001, 1'b0);
    stuck = 1;
    run_req(16'h1234, 4'b0001, 1'b1, 0, cyc);
    stuck = 0;
    chk("timeout write cycles", 64'(wr_cyc), 64'd8);
    chk("timeout busy cycles", 64'(cyc), 64'd9);
    chk("timeout no writes", 64'(got.size()), 64'd0);
    chk("timeout err", 64'(err), 64'd1);
    chk("timeout req_ready", 64'(req_ready), 64'd1);
    chk("timeout bus_req", 64'(bus_req), 64'd0);
    chk("timeout bus released", 64'(data_mask_bus === 4'hF || wr_bus === 1'b1), 64'd0);
    run_req(16'h5678, 4'b0110, 1'b1, 0, cyc);
    chk("err cleared", 64'(err), 64'd0);
    check_writes("after timeout", 16'h5678, 4'b0110, 1'b1);
    for (int r = 0; r < 40; r++) begin
      rv = 16'($urandom);
      rd = 4'($urandom);
      re = 1'($urandom);
      gd = $urandom_range(0, 3);
      hold_n = $urandom_range(0, 2);
      if (r % 4 == 0) rv = rv >> (4 * (r % 16 / 4));
      run_req(rv, rd, re, gd, cyc);
      chk($sformatf("rand%0d latency", r), 64'(cyc), 64'(1 + gd + 3 * (3 + hold_n)));
      check_writes($sformatf("rand%0d", r), rv, rd, re);
    end
    hold_n = 0;
    @(negedge clk);
    req_value = 16'hCAFE;
    req_dots = 4'b1111;
    req_en = 1;
    req_valid = 1;
    @(negedge clk);
    req_valid = 0;
    n = 0;
    while (!(wr_bus === 1'b1 && addr_bus === BASE + 32'd4) && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("digits write reached", 64'(n < 50), 64'd1);
    #1 rst = 1;
    #1;
    chk("async rst bus released", 64'(data_mask_bus === 4'hF || wr_bus === 1'b1 || data_bus === 32'h8C8A8F8E), 64'd0);
    chk("async rst req_ready", 64'(req_ready), 64'd1);
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst bus_req", 64'(bus_req), 64'd0);
    chk("async rst err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 0;
    run_req(16'h004F, 4'b0010, 1'b1, 0, cyc);
    chk("post rst latency", 64'(cyc), 64'd10);
    check_writes("post rst", 16'h004F, 4'b0010, 1'b1);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
